mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the EXE-stage ALU of the 5-stage pipeline and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Exposes busy so the hazard logic stalls MFHI/MFLO and further mul/div ops.
- Generalises the single-cycle EXE datapath to a multi-cycle, width-parametrised engine with abort (flush) support.

Parameters:
WIDTH, 32, operand/HI/LO width; even, >= 4.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  op request, sampled on clk edge
op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op
a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
b  input  WIDTH  rt operand (multiplier / divisor)
cancel  input  1  pipeline flush; aborts the in-flight op
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse: HI/LO just updated by a mul/div
div_by_zero  output  1  registered with done; high if the completed op was a divide with b==0

Behaviour:
- Reset (async, any state, mid-operation included): hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0.
- States: IDLE, CALC, FIX. busy = (state != IDLE); decoded from registered state only.
- IDLE, start=1, cancel=0:
  - op MTHI: hi<=a next edge; MTLO: lo<=a next edge; no busy, no done.
  - op mul/div: latch |a|, |b| (signed ops: two's-complement abs; unsigned ops: raw), result signs, op kind; counter<=WIDTH; state->CALC.
  - op 11x: ignored.
- start while busy: ignored (no queueing). The pipeline stalls on busy.
- CALC: one iteration per cycle; counter decrements; at counter==1 the state goes to FIX.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing a WIDTH-bit quotient and remainder.
- FIX: one cycle. On the edge leaving FIX:
  - apply sign correction, write hi/lo, done<=1, state->IDLE.
  - Multiply: {hi,lo} = product, negated over 2*WIDTH bits if sign(a)^sign(b) for MULT.
  - Divide: lo = quotient, negated if sign(a)^sign(b) (DIV); hi = remainder, sign follows dividend (DIV).
- Latency: a start accepted at edge 0 makes busy high for cycles 1..WIDTH+1. HI/LO and done are valid after edge WIDTH+1, concurrent with busy=0. A new start in the done cycle is accepted.
- Divide by zero (b==0, DIV or DIVU): still takes the full latency. Result is hi=a (original), lo=all ones, div_by_zero=1. Otherwise div_by_zero=0 on done.
- Overflow case DIV most-negative / -1: lo=most-negative (wrap), hi=0. No flag.
- All arithmetic wraps modulo 2^WIDTH (2^(2*WIDTH) for the product).
- cancel:
  - If busy: state->IDLE next edge; hi/lo unchanged; no done.
  - If idle: any simultaneous start is suppressed (cancel wins, MTHI/MTLO included).
- done and div_by_zero deassert the cycle after their pulse.

Test Plan:
- Reset mid-CALC, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> reset forces hi=lo=0, busy=0 asynchronously; after the op, busy high exactly 33 cycles, then hi=0xFFFFFFFE lo=0x00000001 with a 1-cycle done.
- MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; div_by_zero=0.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3 hi=1. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- DIVU a=5 b=0 -> after 33 cycles hi=5 lo=0xFFFFFFFF, done=1, div_by_zero=1 for one cycle.
- MULTU started; start with DIVU asserted at cycle 5 (ignored); cancel at cycle 10 -> busy low next edge, hi/lo keep prior values, no done ever pulses.
- Idle: MTHI a=0x12345678 -> hi updated next edge, busy stays 0. MTLO with cancel=1 -> lo unchanged. New MULT issued in a done cycle -> accepted, busy rises next edge.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide share one 2*WIDTH accumulator.
module mul_div_unit #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div.
    always_comb begin
        a_neg     = op[0] & a[WIDTH-1];
        b_neg     = op[0] & b[WIDTH-1];
        abs_a     = a_neg ? -a : a;
        abs_b     = b_neg ? -b : b;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
        div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod_fix  = neg_q ? -acc : acc;
        // A zero divisor leaves |a| as the remainder, so the sign fix below restores a.
        quo_fix   = dz ? {WIDTH{1'b1}} : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        case (op)
                            3'b100: hi <= a;
                            3'b101: lo <= a;
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                acc    <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                                opnd   <= op[1] ? abs_b : abs_a;
                                is_div <= op[1];
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= op[1] & a_neg;
                                dz     <= op[1] && (b == '0);
                                cnt    <= CNT_W'(WIDTH);
                                state  <= CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!cancel) begin
                        if (is_div) begin
                            hi          <= rem_fix;
                            lo          <= quo_fix;
                            div_by_zero <= dz;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
